// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack port into a
// small prefetch queue and presents the queue head (with its PC) to decode/control.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   fpc_r, fpc_s;
  logic [31:0]   drop_addr_r, drop_addr_s;
  logic [PW-1:0] rd_ptr_r, rd_ptr_s;
  logic [PW-1:0] wr_ptr_r, wr_ptr_s;
  logic [CW-1:0] count_r, count_s;
  logic [31:0]   q_pc_r   [DEPTH];
  logic [31:0]   q_inst_r [DEPTH];

  logic          imem_req_r, req_s;
  logic [31:0]   imem_addr_r, addr_s;
  logic          inst_valid_r, head_valid_s;
  logic [31:0]   inst_r, head_inst_s;
  logic [31:0]   inst_pc_r, head_pc_s;

  logic          pop_s;
  logic          push_s;

  // Next-state, queue bookkeeping and next values of the registered outputs.
  always_comb begin
    pop_s       = inst_valid_r & ~stall & ~redirect;
    push_s      = (state_r == REQ) & imem_ack & ~redirect;
    state_s     = state_r;
    fpc_s       = fpc_r;
    drop_addr_s = drop_addr_r;
    rd_ptr_s    = rd_ptr_r;
    wr_ptr_s    = wr_ptr_r;
    count_s     = count_r;

    if (redirect) begin
      rd_ptr_s = {PW{1'b0}};
      wr_ptr_s = {PW{1'b0}};
      count_s  = {CW{1'b0}};
      fpc_s    = redirect_pc & 32'hFFFF_FFFC;
      // An unacked request must still complete on the bus, so park it in DROP.
      if ((state_r == REQ) && !imem_ack) begin
        state_s     = DROP;
        drop_addr_s = fpc_r;
      end else if ((state_r == DROP) && !imem_ack) begin
        state_s = DROP;
      end else begin
        state_s = REQ;
      end
    end else begin
      count_s = count_r + CW'(push_s) - CW'(pop_s);
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PW'(1'b1);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PW'(1'b1);
        fpc_s    = fpc_r + 32'd4;
      end else begin
        wr_ptr_s = wr_ptr_r;
        fpc_s    = fpc_r;
      end

      case (state_r)
        IDLE: begin
          if (count_s < DEPTH_C) begin
            state_s = REQ;
          end else begin
            state_s = IDLE;
          end
        end
        REQ: begin
          if (imem_ack && !(count_s < DEPTH_C)) begin
            state_s = IDLE;
          end else begin
            state_s = REQ;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_s = REQ;
          end else begin
            state_s = DROP;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    req_s = (state_s != IDLE);
    if (state_s == DROP) begin
      addr_s = drop_addr_s;
    end else begin
      addr_s = fpc_s;
    end

    // The new head is the word being pushed when nothing older survives this cycle.
    if (count_s == {CW{1'b0}}) begin
      head_valid_s = 1'b0;
      head_inst_s  = NOP;
      head_pc_s    = 32'h0000_0000;
    end else if (push_s && (count_s == CW'(1))) begin
      head_valid_s = 1'b1;
      head_inst_s  = imem_rdata;
      head_pc_s    = fpc_r;
    end else begin
      head_valid_s = 1'b1;
      head_inst_s  = q_inst_r[rd_ptr_s];
      head_pc_s    = q_pc_r[rd_ptr_s];
    end
  end

  // State, queue storage and registered outputs; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      fpc_r        <= RESET_PC;
      drop_addr_r  <= RESET_PC;
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      imem_req_r   <= 1'b0;
      imem_addr_r  <= RESET_PC;
      inst_valid_r <= 1'b0;
      inst_r       <= NOP;
      inst_pc_r    <= 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_r[i]   <= 32'h0000_0000;
        q_inst_r[i] <= NOP;
      end
    end else begin
      state_r      <= state_s;
      fpc_r        <= fpc_s;
      drop_addr_r  <= drop_addr_s;
      rd_ptr_r     <= rd_ptr_s;
      wr_ptr_r     <= wr_ptr_s;
      count_r      <= count_s;
      imem_req_r   <= req_s;
      imem_addr_r  <= addr_s;
      inst_valid_r <= head_valid_s;
      inst_r       <= head_inst_s;
      inst_pc_r    <= head_pc_s;
      if (push_s) begin
        q_pc_r[wr_ptr_r]   <= fpc_r;
        q_inst_r[wr_ptr_r] <= imem_rdata;
      end
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = imem_addr_r;
  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign opcode     = inst_r[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, " imem_req"},   32'(imem_req),   32'(req));
    chk({tag, " imem_addr"},  imem_addr,       addr);
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'(vld));
    chk({tag, " inst"},       inst,            ins);
    chk({tag, " inst_pc"},    inst_pc,         pc);
    chk({tag, " opcode"},     32'(opcode),     32'(ins[6:0]));
  endtask

  // Apply one cycle of inputs; return 1 time unit after the sampling edge.
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                      input logic st, input logic ak, input logic [31:0] dat);
    rst = r; redirect = rd; redirect_pc = rpc; stall = st; imem_ack = ak; imem_rdata = dat;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic        rd;
    logic [31:0] rpc;
    logic        st;
    logic        ak;
    logic [31:0] dat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[15];

  // Reference model: a plain queue of fetched words plus bus bookkeeping.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_drop;
  bit          m_busy;
  bit          m_dropping;

  task automatic model_step(input logic r, input logic rd, input logic [31:0] rpc,
                            input logic st, input logic ak, input logic [31:0] dat);
    bit was_busy;
    bit pop;
    ent_t e;
    if (!r) begin
      mq.delete();
      m_fpc = 32'h0; m_drop = 32'h0; m_busy = 0; m_dropping = 0;
    end else begin
      was_busy = m_busy;
      pop = (mq.size() > 0) && !st && !rd;
      if (rd) begin
        mq.delete();
        if (m_busy && !ak) begin
          if (!m_dropping) begin
            m_dropping = 1;
            m_drop = m_fpc;
          end
        end else begin
          m_dropping = 0;
          m_busy = 1;
        end
        m_fpc = rpc & 32'hFFFF_FFFC;
      end else begin
        if (pop) void'(mq.pop_front());
        if (was_busy && ak) begin
          if (m_dropping) begin
            m_dropping = 0;
          end else begin
            e.pc = m_fpc; e.ins = dat;
            mq.push_back(e);
            m_fpc = m_fpc + 32'd4;
            m_busy = (mq.size() < DEPTH);
          end
        end else if (!was_busy) begin
          m_busy = (mq.size() < DEPTH);
        end
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [31:0] ea;
    ea = m_dropping ? m_drop : m_fpc;
    if (mq.size() > 0) expect_out(tag, m_busy, ea, 1'b1, mq[0].ins, mq[0].pc);
    else               expect_out(tag, m_busy, ea, 1'b0, NOP, 32'h0);
  endtask

  initial begin
    // Zero-wait fetch, stall fill, redirect into DROP, redirect with ack, reset.
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, NOP,           32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h0,   1'b0, NOP,           32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hA000_0001, 1'b1, 32'h4,   1'b1, 32'hA000_0001, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hA000_0102, 1'b1, 32'h8,   1'b1, 32'hA000_0102, 32'h4};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hA000_0203, 1'b1, 32'hC,   1'b1, 32'hA000_0203, 32'h8};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hA000_0304, 1'b0, 32'h10,  1'b1, 32'hA000_0203, 32'h8};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'h10,  1'b1, 32'hA000_0203, 32'h8};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h10,  1'b1, 32'hA000_0304, 32'hC};
    tbl[8]  = '{1'b1, 1'b1, 32'h107, 1'b1, 1'b0, 32'h0,         1'b1, 32'h10,  1'b0, NOP,           32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h10,  1'b0, NOP,           32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h104, 1'b0, NOP,           32'h0};
    tbl[11] = '{1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'hB000_0005, 1'b1, 32'h200, 1'b0, NOP,           32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hB000_0106, 1'b1, 32'h204, 1'b1, 32'hB000_0106, 32'h200};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hB000_0207, 1'b0, 32'h0,   1'b0, NOP,           32'h0};
    tbl[14] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hB000_0308, 1'b1, 32'h0,   1'b0, NOP,           32'h0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].rd, tbl[i].rpc, tbl[i].st, tbl[i].ak, tbl[i].dat);
      expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                 tbl[i].e_inst, tbl[i].e_pc);
    end

    // Stall from reset: queue fills with 0x0/0x4, request drops, head holds 0x0.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_out("st_reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_out("st_req0", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC000_0013);
    expect_out("st_fill1", 1'b1, 32'h4, 1'b1, 32'hC000_0013, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC100_0033);
    expect_out("st_full", 1'b0, 32'h8, 1'b1, 32'hC000_0013, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      expect_out($sformatf("st_hold%0d", k), 1'b0, 32'h8, 1'b1, 32'hC000_0013, 32'h0);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_out("st_resume", 1'b1, 32'h8, 1'b1, 32'hC100_0033, 32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC200_0063);
    expect_out("st_refill", 1'b0, 32'hC, 1'b1, 32'hC100_0033, 32'h4);

    // Redirect while full: flushed next cycle, fetch at 0x104, old entries gone.
    step(1'b1, 1'b1, 32'h0000_0107, 1'b1, 1'b0, 32'h0);
    expect_out("rf_flush", 1'b1, 32'h104, 1'b0, NOP, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hD000_0003);
    expect_out("rf_first", 1'b1, 32'h108, 1'b1, 32'hD000_0003, 32'h104);

    // Redirect while request at 0x108 waits three cycles for its ack.
    step(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
    expect_out("dr_enter", 1'b1, 32'h108, 1'b0, NOP, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out($sformatf("dr_wait%0d", k), 1'b1, 32'h108, 1'b0, NOP, 32'h0);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0);
    expect_out("dr_drop", 1'b1, 32'h200, 1'b0, NOP, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hE000_0017);
    expect_out("dr_new", 1'b1, 32'h204, 1'b1, 32'hE000_0017, 32'h200);

    // Reset with a request pending; the ack on the reset edge is ignored.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    expect_out("rs_mid", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    expect_out("rs_restart", 1'b1, 32'h0, 1'b0, NOP, 32'h0);

    // Randomized traffic against the reference model.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_check("rnd_reset");
    for (int c = 0; c < 3000; c++) begin
      logic        r_r, rd_r, st_r, ak_r;
      logic [31:0] rpc_r, dat_r;
      r_r   = ($urandom_range(0, 199) != 0);
      rd_r  = ($urandom_range(0, 9) == 0);
      st_r  = ($urandom_range(0, 2) == 0);
      ak_r  = ($urandom_range(0, 1) == 1);
      rpc_r = $urandom;
      dat_r = $urandom;
      step(r_r, rd_r, rpc_r, st_r, ak_r, dat_r);
      model_step(r_r, rd_r, rpc_r, st_r, ak_r, dat_r);
      model_check($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
